// File: rtl/ika2151_timinggen_p.sv
// ---------------------------------------------------------------------------
// ika2151_timinggen_p
//
// Parametrised timing generator for the IKA2151 family. It divides the phiM
// enable down to phi1 and produces phi1 edge enables. It also generates the
// synchronised master reset. It runs the operator slot counter with its
// per-slot decodes, and a frame counter.
//
// Ports:
//   i_EMUCLK          master clock (only clock)
//   i_IC_n            synchronous active-low reset
//   i_phiM_PCEN_n     phiM enable, active-low, one i_EMUCLK wide
//   o_MRST_n          synchronised master reset to the other blocks
//   o_phi1            phi1 level
//   o_phi1_PCEN_n     low on the cycle before phi1 rises
//   o_phi1_NCEN_n     low on the cycle before phi1 falls
//   o_SH1 / o_SH2     DAC sample-and-hold strobes
//   o_SLOT            current slot index
//   o_CH / o_OP       slot mod CH / slot div CH
//   o_CYCLE_*         fixed per-slot decodes
//   o_FRAME           frames completed since o_MRST_n release
// ---------------------------------------------------------------------------
module ika2151_timinggen_p #(
  parameter int PHI_DIV   = 2,
  parameter int SLOTS     = 32,
  parameter int CH        = 8,
  parameter int RST_HOLD  = 4,
  parameter int SH1_START = 0,
  parameter int SH2_START = 16,
  parameter int SH_LEN    = 8,
  parameter int FRAME_W   = 8,
  localparam int SW       = $clog2(SLOTS),
  localparam int CHW      = $clog2(CH)
) (
  input  logic               i_EMUCLK,
  input  logic               i_IC_n,
  input  logic               i_phiM_PCEN_n,
  output logic               o_MRST_n,
  output logic               o_phi1,
  output logic               o_phi1_PCEN_n,
  output logic               o_phi1_NCEN_n,
  output logic               o_SH1,
  output logic               o_SH2,
  output logic [SW-1:0]      o_SLOT,
  output logic [CHW-1:0]     o_CH,
  output logic [SW-CHW-1:0]  o_OP,
  output logic               o_CYCLE_31,
  output logic               o_CYCLE_00_16,
  output logic               o_CYCLE_01_TO_16,
  output logic               o_CYCLE_12_28,
  output logic               o_CYCLE_05_21,
  output logic               o_CYCLE_BYTE,
  output logic [FRAME_W-1:0] o_FRAME
);

  localparam int HALF = PHI_DIV / 2;
  localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int HW   = $clog2(RST_HOLD + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(HALF - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
  localparam logic [SW-1:0] SH1_OFS   = SW'(SH1_START);
  localparam logic [SW-1:0] SH2_OFS   = SW'(SH2_START);
  // One extra bit so SH_LEN == SLOTS (always-on window) stays representable.
  localparam logic [SW:0]   SH_LEN_W  = (SW + 1)'(SH_LEN);
  localparam logic [SW:0]   SLOT_16   = (SW + 1)'(16);

  logic [DW-1:0]      div_q,   div_d;
  logic               phi1_q,  phi1_d;
  logic               mrst_q,  mrst_d;
  logic [HW-1:0]      hold_q,  hold_d;
  logic [SW-1:0]      slot_q,  slot_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  logic phim_en, div_tc, tog_en, pcen;
  logic [SW-1:0] sh1_rel, sh2_rel;

  always_comb begin
    phim_en = ~i_phiM_PCEN_n;
    div_tc  = (div_q == DIV_LAST);
    tog_en  = phim_en & div_tc;
    pcen    = tog_en & ~phi1_q;

    div_d   = div_q;
    if (phim_en) div_d = div_tc ? '0 : div_q + DW'(1);
    phi1_d  = phi1_q ^ tog_en;

    hold_d  = hold_q;
    mrst_d  = mrst_q;
    slot_d  = slot_q;
    frame_d = frame_q;
    if (pcen) begin
      if (!mrst_q) begin
        // Release lands on the RST_HOLD-th phi1 rising edge; slot stays 0
        // on that edge so slot 0 gets a full phi1 period afterwards.
        if (hold_q == HOLD_LAST) mrst_d = 1'b1;
        else                     hold_d = hold_q + HW'(1);
      end else begin
        slot_d = slot_q + SW'(1);  // SLOTS is a power of two: wraps itself
        if (slot_q == SLOT_LAST) frame_d = frame_q + FRAME_W'(1);
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (!i_IC_n) begin
      div_q   <= '0;
      phi1_q  <= 1'b0;
      mrst_q  <= 1'b0;
      hold_q  <= '0;
      slot_q  <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      phi1_q  <= phi1_d;
      mrst_q  <= mrst_d;
      hold_q  <= hold_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  // Window test as a modular distance from the window start, so windows
  // that run past SLOTS-1 need no special casing.
  always_comb begin
    sh1_rel = slot_q - SH1_OFS;
    sh2_rel = slot_q - SH2_OFS;
  end

  assign o_MRST_n         = mrst_q;
  assign o_phi1           = phi1_q;
  assign o_phi1_PCEN_n    = ~(tog_en & ~phi1_q);
  assign o_phi1_NCEN_n    = ~(tog_en & phi1_q);
  assign o_SH1            = ({1'b0, sh1_rel} < SH_LEN_W);
  assign o_SH2            = ({1'b0, sh2_rel} < SH_LEN_W);
  assign o_SLOT           = slot_q;
  assign o_CH             = slot_q[CHW-1:0];
  assign o_OP             = slot_q[SW-1:CHW];
  assign o_CYCLE_31       = (slot_q == SLOT_LAST);
  assign o_CYCLE_00_16    = (slot_q[3:0] == 4'd0);
  assign o_CYCLE_01_TO_16 = (slot_q != '0) && ({1'b0, slot_q} <= SLOT_16);
  assign o_CYCLE_12_28    = (slot_q[3:0] == 4'd12);
  assign o_CYCLE_05_21    = (slot_q[3:0] == 4'd5);
  assign o_CYCLE_BYTE     = (slot_q[2:0] == 3'd7);
  assign o_FRAME          = frame_q;

endmodule

// File: tb/tb_ika2151_timinggen_p.sv
module tb_ika2151_timinggen_p;

  logic clk = 1'b0;
  logic ic_n = 1'b0;
  logic pcen_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // dut0: defaults, dut1: SH1_START=28, dut2: PHI_DIV=6 SLOTS=64 CH=16
  logic       mrst0, phi0, pc0, nc0, sh1_0, sh2_0, c31_0, c0016_0, c0116_0, c1228_0, c0521_0, cb_0;
  logic [4:0] slot0;
  logic [2:0] ch0;
  logic [1:0] op0;
  logic [7:0] frame0;
  logic       mrst1, phi1x, pc1, nc1, sh1_1, sh2_1, c31_1, c0016_1, c0116_1, c1228_1, c0521_1, cb_1;
  logic [4:0] slot1;
  logic [2:0] ch1;
  logic [1:0] op1;
  logic [7:0] frame1;
  logic       mrst2, phi2, pc2, nc2, sh1_2, sh2_2, c31_2, c0016_2, c0116_2, c1228_2, c0521_2, cb_2;
  logic [5:0] slot2;
  logic [3:0] ch2;
  logic [1:0] op2;
  logic [7:0] frame2;

  ika2151_timinggen_p dut0 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n),
    .o_MRST_n(mrst0), .o_phi1(phi0), .o_phi1_PCEN_n(pc0), .o_phi1_NCEN_n(nc0),
    .o_SH1(sh1_0), .o_SH2(sh2_0), .o_SLOT(slot0), .o_CH(ch0), .o_OP(op0),
    .o_CYCLE_31(c31_0), .o_CYCLE_00_16(c0016_0), .o_CYCLE_01_TO_16(c0116_0),
    .o_CYCLE_12_28(c1228_0), .o_CYCLE_05_21(c0521_0), .o_CYCLE_BYTE(cb_0),
    .o_FRAME(frame0));

  ika2151_timinggen_p #(.SH1_START(28)) dut1 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n),
    .o_MRST_n(mrst1), .o_phi1(phi1x), .o_phi1_PCEN_n(pc1), .o_phi1_NCEN_n(nc1),
    .o_SH1(sh1_1), .o_SH2(sh2_1), .o_SLOT(slot1), .o_CH(ch1), .o_OP(op1),
    .o_CYCLE_31(c31_1), .o_CYCLE_00_16(c0016_1), .o_CYCLE_01_TO_16(c0116_1),
    .o_CYCLE_12_28(c1228_1), .o_CYCLE_05_21(c0521_1), .o_CYCLE_BYTE(cb_1),
    .o_FRAME(frame1));

  ika2151_timinggen_p #(.PHI_DIV(6), .SLOTS(64), .CH(16)) dut2 (
    .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phiM_PCEN_n(pcen_n),
    .o_MRST_n(mrst2), .o_phi1(phi2), .o_phi1_PCEN_n(pc2), .o_phi1_NCEN_n(nc2),
    .o_SH1(sh1_2), .o_SH2(sh2_2), .o_SLOT(slot2), .o_CH(ch2), .o_OP(op2),
    .o_CYCLE_31(c31_2), .o_CYCLE_00_16(c0016_2), .o_CYCLE_01_TO_16(c0116_2),
    .o_CYCLE_12_28(c1228_2), .o_CYCLE_05_21(c0521_2), .o_CYCLE_BYTE(cb_2),
    .o_FRAME(frame2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs settle 1 ns later.
  task automatic drive(input logic ic, input logic en);
    @(negedge clk);
    ic_n   = ic;
    pcen_n = ~en;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  // One phi1 period of dut0 with a phiM enable on every second clock.
  task automatic period0();
    drive(1'b1, 1'b1);
    chk("pcen_rise", 32'(pc0), 32'd0);
    chk("ncen_rise", 32'(nc0), 32'd1);
    edge_wait();
    chk("phi1_hi", 32'(phi0), 32'd1);
    drive(1'b1, 1'b0);
    chk("cen_idle", 32'({pc0, nc0}), 32'd3);
    edge_wait();
    drive(1'b1, 1'b1);
    chk("pcen_fall", 32'(pc0), 32'd1);
    chk("ncen_fall", 32'(nc0), 32'd0);
    edge_wait();
    chk("phi1_lo", 32'(phi0), 32'd0);
    drive(1'b1, 1'b0);
    edge_wait();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, cnt0116, p;
    bit en;
    logic [31:0] snap_a, snap_b;

    // ---------------- reset state ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i % 2) == 0);
      edge_wait();
    end
    drive(1'b0, 1'b0);
    chk("rst_phi1", 32'(phi0), 32'd0);
    chk("rst_mrst", 32'(mrst0), 32'd0);
    chk("rst_slot", 32'(slot0), 32'd0);
    chk("rst_frame", 32'(frame0), 32'd0);
    chk("rst_cen", 32'({pc0, nc0}), 32'd3);
    chk("rst_sh1", 32'(sh1_0), 32'd1);
    chk("rst_sh2", 32'(sh2_0), 32'd0);
    chk("rst_c0016", 32'(c0016_0), 32'd1);
    chk("rst_sh1_wrap", 32'(sh1_1), 32'd1);
    $display("step reset: slot=%0d mrst=%0d phi1=%0d", slot0, mrst0, phi0);

    // ---------------- reset hold ----------------
    for (int pp = 1; pp <= 4; pp++) begin
      period0();
      chk("hold_mrst", 32'(mrst0), 32'(pp == 4));
      chk("hold_slot", 32'(slot0), 32'd0);
      $display("step hold %0d: mrst=%0d slot=%0d", pp, mrst0, slot0);
    end

    // ---------------- one full frame with decode sweep ----------------
    cnt0116 = 0;
    for (int k = 1; k <= 32; k++) begin
      period0();
      s = k % 32;
      chk("slot", 32'(slot0), 32'(s));
      chk("frame", 32'(frame0), 32'(k / 32));
      chk("c31", 32'(c31_0), 32'(s == 31));
      chk("c0016", 32'(c0016_0), 32'(s == 0 || s == 16));
      chk("c1228", 32'(c1228_0), 32'(s == 12 || s == 28));
      chk("c0521", 32'(c0521_0), 32'(s == 5 || s == 21));
      chk("c0116", 32'(c0116_0), 32'(s >= 1 && s <= 16));
      chk("cbyte", 32'(cb_0), 32'(s == 7 || s == 15 || s == 23 || s == 31));
      chk("sh1", 32'(sh1_0), 32'(s <= 7));
      chk("sh2", 32'(sh2_0), 32'(s >= 16 && s <= 23));
      chk("sh_overlap", 32'(sh1_0 & sh2_0), 32'd0);
      chk("sh1_wrap", 32'(sh1_1), 32'(s >= 28 || s <= 3));
      chk("ch", 32'(ch0), 32'(s % 8));
      chk("op", 32'(op0), 32'(s / 8));
      if (c0116_0) cnt0116++;
      $display("step frame slot=%0d ch=%0d op=%0d sh1=%0d sh2=%0d frame=%0d",
               slot0, ch0, op0, sh1_0, sh2_0, frame0);
    end
    chk("c0116_count", 32'(cnt0116), 32'd16);

    // ---------------- reset mid-frame at slot 20 ----------------
    for (int k = 1; k <= 20; k++) period0();
    chk("pre_rst_slot", 32'(slot0), 32'd20);
    chk("slot19_free", 32'(frame0), 32'd1);
    drive(1'b0, 1'b1);
    edge_wait();
    chk("mid_rst_slot", 32'(slot0), 32'd0);
    chk("mid_rst_mrst", 32'(mrst0), 32'd0);
    chk("mid_rst_phi1", 32'(phi0), 32'd0);
    chk("mid_rst_frame", 32'(frame0), 32'd0);
    $display("step midreset: slot=%0d mrst=%0d phi1=%0d", slot0, mrst0, phi0);
    drive(1'b1, 1'b0);
    edge_wait();
    for (int pp = 1; pp <= 4; pp++) begin
      period0();
      chk("rehold_mrst", 32'(mrst0), 32'(pp == 4));
    end
    period0();
    chk("rehold_slot1", 32'(slot0), 32'd1);

    // ---------------- random enable gaps ----------------
    for (int i = 0; i < 200; i++) begin
      en = 1'($urandom_range(0, 1));
      snap_a = {phi0, mrst0, slot0, frame0, phi2, slot2, 10'd0};
      drive(1'b1, en);
      chk("cen_excl0", 32'(!pc0 && !nc0), 32'd0);
      chk("cen_excl2", 32'(!pc2 && !nc2), 32'd0);
      edge_wait();
      snap_b = {phi0, mrst0, slot0, frame0, phi2, slot2, 10'd0};
      if (!en) chk("gap_hold", snap_b, snap_a);
    end
    $display("step gaps: slot0=%0d slot2=%0d", slot0, slot2);

    // ---------------- PHI_DIV=6, SLOTS=64, CH=16 ----------------
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i % 2) == 0);
      edge_wait();
    end
    for (int e = 1; e <= 420; e++) begin
      drive(1'b1, 1'b1);
      chk("d6_pcen", 32'(pc2), 32'(!(e % 6 == 3)));
      chk("d6_ncen", 32'(nc2), 32'(!(e % 6 == 0)));
      edge_wait();
      if (e <= 12) chk("d6_phi1", 32'(phi2), 32'((e / 3) % 2));
      if (e % 6 == 3) begin
        p = (e + 3) / 6;
        chk("d6_mrst", 32'(mrst2), 32'(p >= 4));
        if (p >= 60) begin
          chk("d6_slot", 32'(slot2), 32'((p - 4) % 64));
          chk("d6_c31", 32'(c31_2), 32'(((p - 4) % 64) == 63));
          $display("step div6 pcen=%0d slot=%0d c31=%0d", p, slot2, c31_2);
        end
      end
      drive(1'b1, 1'b0);
      edge_wait();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ika2151_timinggen_p.md
# ika2151_timinggen_p

Parametrised timing generator for the IKA2151 family. It derives phi1 and its edge-enables from the phiM enable, and generates the synchronised master reset. It also runs the operator slot counter and decodes the per-slot strobes consumed by REG, LFO, PG and EG. It generalises the fixed 32-slot generator in three ways: configurable divider and slot count, configurable SH1/SH2 windows, and exported slot/channel/operator indices plus a frame counter.

## Interface
Parameters:
- PHI_DIV, 2: phiM enables per phi1 period; even, ≥2.
- SLOTS, 32: slots per frame; power of two, ≥16.
- CH, 8: channels per frame; SLOTS/CH operators per channel; power of two.
- RST_HOLD, 4: phi1 periods o_MRST_n stays low after i_IC_n release; ≥1.
- SH1_START, 0: first slot of the SH1 high window.
- SH2_START, 16: first slot of the SH2 high window.
- SH_LEN, 8: SH window length in slots; 1..SLOTS.
- FRAME_W, 8: frame counter width.

Ports (SW = $clog2(SLOTS)):
- i_EMUCLK  in  1  emulator master clock; the only clock.
- i_IC_n  in  1  reset; synchronous, active-low, sampled on i_EMUCLK.
- i_phiM_PCEN_n  in  1  phiM enable; active-low, one i_EMUCLK wide.
- o_MRST_n  out  1  synchronised master reset to all other blocks.
- o_phi1  out  1  phi1 level.
- o_phi1_PCEN_n  out  1  low on the i_EMUCLK cycle before phi1 rises.
- o_phi1_NCEN_n  out  1  low on the i_EMUCLK cycle before phi1 falls.
- o_SH1, o_SH2  out  1  DAC sample-and-hold strobes.
- o_SLOT  out  SW  current slot index.
- o_CH  out  $clog2(CH)  slot mod CH.
- o_OP  out  SW-$clog2(CH)  slot / CH.
- o_CYCLE_31  out  1  slot == SLOTS-1.
- o_CYCLE_00_16  out  1  slot[3:0] == 0.
- o_CYCLE_01_TO_16  out  1  1 ≤ slot ≤ 16.
- o_CYCLE_12_28  out  1  slot[3:0] == 12.
- o_CYCLE_05_21  out  1  slot[3:0] == 5.
- o_CYCLE_BYTE  out  1  slot[2:0] == 7.
- o_FRAME  out  FRAME_W  frames completed since o_MRST_n release; wraps.

## Operation
- **Reset (i_IC_n low at a clock edge).** All state clears on that edge.
  - Reset outputs: o_phi1=0, both CEN_n=1, o_MRST_n=0, o_SLOT=0, o_FRAME=0.
  - Decodes and SH strobes follow from slot=0.
- **Divider.**
  - A counter of PHI_DIV/2 steps advances only when i_phiM_PCEN_n=0.
  - On its terminal count, phi1 toggles.
  - o_phi1_PCEN_n=0 exactly when the toggle is enabled this cycle and phi1=0. o_phi1_NCEN_n=0 exactly when the toggle is enabled this cycle and phi1=1.
  - The CEN outputs are combinational from registered state and i_phiM_PCEN_n. They are never both low.
- **Reset hold.**
  - After i_IC_n returns high, o_MRST_n stays 0 for RST_HOLD phi1 rising edges, counted on PCEN.
  - o_MRST_n is registered and goes 1 on the edge of the RST_HOLD-th PCEN.
- **Slot counter.**
  - Held at 0 while o_MRST_n=0.
  - Otherwise it increments on every phi1 PCEN and wraps SLOTS-1 → 0.
  - o_FRAME increments on the same edge as that wrap.
- **Decodes.** All cycle decodes, o_CH, o_OP, o_SH1 and o_SH2 are combinational from the slot register, so they change only on PCEN edges.
- **SH windows.** o_SHx=1 when (slot − SHx_START) mod SLOTS < SH_LEN. Windows may wrap past SLOTS-1.
- **Inactive edges.** i_phiM_PCEN_n=1 never changes any state.

## Timing
- phi1 period = PHI_DIV phiM enables. The high and low phases are equal (PHI_DIV/2 enables each).
- Slot period = one phi1 period. Frame = SLOTS phi1 periods.
- Latency from a phiM enable edge:
  - 0 cycles: CEN outputs.
  - 1 i_EMUCLK: phi1, slot, decodes, o_MRST_n.
- **Reset mid-operation.** i_IC_n low at any cycle, including a PCEN cycle, wins over every increment. Hold restarts from 0 on the next release.
- **i_IC_n pulse shorter than one phi1 period.** It is still a full reset; hold is RST_HOLD from release.
- **First slot after reset.** The first slot after o_MRST_n rises is slot 0, lasting one full phi1 period.
- **o_FRAME overflow.** It wraps 2^FRAME_W − 1 → 0 without a flag.

## Test plan
- **Defaults, phiM enable every 2nd i_EMUCLK, i_IC_n low 10 cycles then high.**
  - phi1 period = 4 i_EMUCLK.
  - o_MRST_n rises on the 4th PCEN after release.
  - o_SLOT then counts 0..31 and wraps.
  - o_FRAME = 1 after 32 PCENs past release.
- **Decode sweep at defaults.**
  - o_CYCLE_31 only at slot 31.
  - o_CYCLE_00_16 at slots 0 and 16; o_CYCLE_12_28 at 12 and 28; o_CYCLE_05_21 at 5 and 21.
  - o_CYCLE_01_TO_16 high for exactly 16 slots.
  - o_CYCLE_BYTE at 7, 15, 23, 31.
  - At slot 19: o_CH = 3, o_OP = 2.
- **SH windows at defaults.** SH1 high for slots 0–7, SH2 high for slots 16–23, never overlapping. With SH1_START=28, SH1 is high at slots 28–31 and 0–3.
- **PHI_DIV=6, SLOTS=64, CH=16.**
  - phi1 high for 3 enables, low for 3.
  - Slot wraps 63 → 0.
  - o_CYCLE_31 only at slot 63.
- **Reset mid-frame.** i_IC_n low for 1 i_EMUCLK coinciding with PCEN at slot 20: on the next cycle slot=0, o_MRST_n=0, phi1=0; full RST_HOLD sequence repeats.
- **Enable gaps.** Randomly withheld i_phiM_PCEN_n: no state change on any cycle without an enable, and PCEN/NCEN are never simultaneously low.
